// File: rtl/fpu_op_issuer_if.sv
// Host-side request/response channels of the FPU operation issuer.
// The host drives requests and accepts responses; the issuer does the reverse.
interface fpu_op_issuer_if #(
    parameter int unsigned WIDTH = 32
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [1:0]       req_op;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_timeout;

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_timeout
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_timeout
    );
endinterface

// File: rtl/fpu_op_issuer.sv
// FPU operation issuer: accepts one host request, runs the four-phase
// start/done handshake with the FPU control unit (with a timeout guard),
// and returns the captured result on the response channel.
module fpu_op_issuer #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    fpu_op_issuer_if.slave    host,
    output logic              fpu_start,
    output logic [WIDTH-1:0]  fpu_in_a,
    output logic [WIDTH-1:0]  fpu_in_b,
    output logic [1:0]        fpu_op,
    input  logic [WIDTH-1:0]  fpu_out,
    input  logic              fpu_done,
    output logic              busy,
    output logic [CNT_W-1:0]  op_count
);
    localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DRAIN = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [TW-1:0]    cnt_q, cnt_d;
    logic             fpu_start_q, fpu_start_d;
    logic [WIDTH-1:0] fpu_in_a_q, fpu_in_a_d;
    logic [WIDTH-1:0] fpu_in_b_q, fpu_in_b_d;
    logic [1:0]       fpu_op_q, fpu_op_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic             rsp_timeout_q, rsp_timeout_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;
    logic             req_ready_w;

    // A stale high done from a previous operation blocks acceptance; held low in reset.
    assign req_ready_w = rst_n && (state_q == IDLE) && !fpu_done;

    assign host.req_ready   = req_ready_w;
    assign host.rsp_valid   = rsp_valid_q;
    assign host.rsp_result  = rsp_result_q;
    assign host.rsp_timeout = rsp_timeout_q;
    assign fpu_start        = fpu_start_q;
    assign fpu_in_a         = fpu_in_a_q;
    assign fpu_in_b         = fpu_in_b_q;
    assign fpu_op           = fpu_op_q;
    assign busy             = (state_q != IDLE);
    assign op_count         = op_count_q;

    // Next-state and next-output computation for the handshake sequencer.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        fpu_start_d   = fpu_start_q;
        fpu_in_a_d    = fpu_in_a_q;
        fpu_in_b_d    = fpu_in_b_q;
        fpu_op_d      = fpu_op_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_result_d  = rsp_result_q;
        rsp_timeout_d = rsp_timeout_q;
        op_count_d    = op_count_q;
        unique case (state_q)
            IDLE: begin
                if (host.req_valid && req_ready_w) begin
                    fpu_in_a_d  = host.req_a;
                    fpu_in_b_d  = host.req_b;
                    fpu_op_d    = host.req_op;
                    fpu_start_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = START;
                end
            end
            START: begin
                cnt_d = cnt_q + 1'b1;
                // done wins over timeout when both land on the same cycle
                if (fpu_done) begin
                    rsp_result_d  = fpu_out;
                    rsp_timeout_d = 1'b0;
                    fpu_start_d   = 1'b0;
                    op_count_d    = op_count_q + 1'b1;
                    state_d       = DRAIN;
                end else if (cnt_q == TW'(TIMEOUT - 1)) begin
                    rsp_result_d  = '0;
                    rsp_timeout_d = 1'b1;
                    fpu_start_d   = 1'b0;
                    state_d       = DRAIN;
                end
            end
            DRAIN: begin
                if (!fpu_done) begin
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (host.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; async reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            fpu_start_q   <= 1'b0;
            fpu_in_a_q    <= '0;
            fpu_in_b_q    <= '0;
            fpu_op_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_result_q  <= '0;
            rsp_timeout_q <= 1'b0;
            op_count_q    <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            fpu_start_q   <= fpu_start_d;
            fpu_in_a_q    <= fpu_in_a_d;
            fpu_in_b_q    <= fpu_in_b_d;
            fpu_op_q      <= fpu_op_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_result_q  <= rsp_result_d;
            rsp_timeout_q <= rsp_timeout_d;
            op_count_q    <= op_count_d;
        end
    end
endmodule
